// File: rtl/msx_cart_reconfig_seq_pkg.sv
// Shared MSX cartridge types and the reconfiguration sequencer state encoding.
// The state enum is kept here so debug taps elsewhere can decode it.
package msx_cart_reconfig_seq_pkg;

    typedef enum logic [2:0] {
        CART_TYP_ROM      = 3'd0,
        CART_TYP_SCC      = 3'd1,
        CART_TYP_SCC_PLUS = 3'd2,
        CART_TYP_FM_PAC   = 3'd3,
        CART_TYP_MFRSD    = 3'd4,
        CART_TYP_GM2      = 3'd5,
        CART_TYP_FDC      = 3'd6,
        CART_TYP_EMPTY    = 3'd7
    } cart_typ_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_WAIT_A = 3'd3,
        ST_LOAD_B = 3'd4,
        ST_WAIT_B = 3'd5,
        ST_HOLD   = 3'd6
    } reconfig_state_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/msx_seq_counter.sv
// Clear/load/saturating up-counter with a terminal-count compare against a limit.
module msx_seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= WIDTH'(count + 1'b1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/msx_cart_reconfig_seq.sv
// Cartridge reconfiguration sequencer: debounce config change, hold core reset,
// reload slot A then slot B via req/ack, then release reset. Optional load
// watchdog is enabled with `define CART_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | core running, watching for config change
// SETTLE    | core in reset, waiting for SETTLE_CYCLES of quiet
// LOAD_A    | decide whether slot A needs a reload
// WAIT_A    | load_req high for slot A, waiting for load_ack
// LOAD_B    | decide whether slot B needs a reload
// WAIT_B    | load_req high for slot B, waiting for load_ack
// HOLD      | keep core in reset HOLD_CYCLES after the last load
module msx_cart_reconfig_seq
    import msx_cart_reconfig_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reset_request,
    input  logic       cart_changed,
    input  logic [2:0] cart_typ [2],
    output logic       load_req,
    output logic       load_slot,
    input  logic       load_ack,
    output logic       msx_reset,
    output logic       busy,
    output logic [1:0] load_timeout
);

    if (SETTLE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("msx_cart_reconfig_seq: cycle parameters must be >= 1");
    end

    localparam int CW = cnt_width(max2(SETTLE_CYCLES, HOLD_CYCLES));
    localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LIM   = CW'(HOLD_CYCLES - 1);

    reconfig_state_t state, state_nxt;
    logic            change;
    logic            pending;
    logic            waiting;
    logic            to_expire;
    logic            sh_clr, sh_en, sh_tc;
    logic [CW-1:0]   sh_limit;

    assign change  = reset_request | cart_changed;
    assign waiting = (state == ST_WAIT_A) || (state == ST_WAIT_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (change) state_nxt = ST_SETTLE;
            ST_SETTLE: if (!change && sh_tc) state_nxt = ST_LOAD_A;
            ST_LOAD_A: state_nxt = (cart_typ[0] == CART_TYP_EMPTY) ? ST_LOAD_B : ST_WAIT_A;
            ST_WAIT_A: if (load_ack || to_expire) state_nxt = ST_LOAD_B;
            ST_LOAD_B: state_nxt = (cart_typ[1] == CART_TYP_EMPTY) ? ST_HOLD : ST_WAIT_B;
            ST_WAIT_B: if (load_ack || to_expire) state_nxt = ST_HOLD;
            ST_HOLD: begin
                // a change landing in the expiry cycle still forces another pass
                if (sh_tc) state_nxt = (pending || change) ? ST_SETTLE : ST_IDLE;
            end
            default:   state_nxt = ST_LOAD_A;
        endcase
    end

    // Outputs decode straight from state so an async reset drops load_req at once.
    assign load_req  = waiting;
    assign load_slot = (state == ST_LOAD_B) || (state == ST_WAIT_B);
    assign msx_reset = (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if ((state == ST_HOLD) && sh_tc) begin
            pending <= 1'b0;
        end else if (change && (state inside {ST_LOAD_A, ST_WAIT_A, ST_LOAD_B, ST_WAIT_B, ST_HOLD})) begin
            pending <= 1'b1;
        end
    end

    // One counter serves both SETTLE and HOLD; it restarts on every state change.
    assign sh_clr   = (state_nxt != state) || ((state == ST_SETTLE) && change);
    assign sh_en    = (state == ST_SETTLE) || (state == ST_HOLD);
    assign sh_limit = (state == ST_HOLD) ? HOLD_LIM : SETTLE_LIM;

    msx_seq_counter #(
        .WIDTH (CW)
    ) u_settle_hold_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (sh_clr),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       (sh_en),
        .limit    (sh_limit),
        .tc       (sh_tc)
    );

`ifdef CART_SEQ_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES - 1);

    logic       to_tc;
    logic [1:0] timeout_q;

    msx_seq_counter #(
        .WIDTH (TW)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (reset),
        .clr      (state_nxt != state),
        .load     (1'b0),
        .load_val ({TW{1'b0}}),
        .en       (waiting),
        .limit    (TIMEOUT_LIM),
        .tc       (to_tc)
    );

    assign to_expire = waiting && to_tc;

    // An ack arriving in the expiry cycle wins; the slot is not flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 2'b00;
        end else if (to_expire && !load_ack) begin
            if (state == ST_WAIT_A) timeout_q[0] <= 1'b1;
            else                    timeout_q[1] <= 1'b1;
        end
    end

    assign load_timeout = timeout_q;
`else
    assign to_expire    = 1'b0;
    assign load_timeout = 2'b00;
`endif

endmodule

// File: tb/tb_msx_cart_reconfig_seq.sv
// Directed bench for msx_cart_reconfig_seq with short settle/hold/timeout windows.
module tb_msx_cart_reconfig_seq;
    import msx_cart_reconfig_seq_pkg::*;

    localparam int S = 16;
    localparam int H = 8;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_request;
    logic       cart_changed;
    logic [2:0] cart_typ [2];
    logic       load_req;
    logic       load_slot;
    logic       load_ack;
    logic       msx_reset;
    logic       busy;
    logic [1:0] load_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    msx_cart_reconfig_seq #(
        .SETTLE_CYCLES  (S),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reset_request (reset_request),
        .cart_changed  (cart_changed),
        .cart_typ      (cart_typ),
        .load_req      (load_req),
        .load_slot     (load_slot),
        .load_ack      (load_ack),
        .msx_reset     (msx_reset),
        .busy          (busy),
        .load_timeout  (load_timeout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        cart_changed = 1'b1;
        tick();
        cart_changed = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!load_req && n < 200);
    endtask

    task automatic serve(input int slot, input int delay, input string tag);
        check_val({tag, "_req"}, load_req, 1);
        check_val({tag, "_slot"}, load_slot, slot);
        repeat (delay) tick();
        check_val({tag, "_req_held"}, load_req, 1);
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check_val({tag, "_req_drop"}, load_req, 0);
    endtask

    // Counts cycles from the ack cycle to msx_reset low.
    task automatic wait_release(output int n);
        n = 1;
        while (msx_reset && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Counts cycles from the ack cycle to the next load_req, watching msx_reset.
    task automatic wait_rerun(output int n, output logic low_seen);
        n = 1;
        low_seen = 1'b0;
        while (!load_req && n < 200) begin
            tick();
            n++;
            if (!msx_reset) low_seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   c;
        logic low_seen;

        reset         = 1'b1;
        reset_request = 1'b0;
        cart_changed  = 1'b0;
        load_ack      = 1'b0;
        cart_typ[0]   = CART_TYP_ROM;
        cart_typ[1]   = CART_TYP_ROM;
        #1;
        check_val("rst_msx_reset", msx_reset, 1);
        check_val("rst_load_req", load_req, 0);
        check_val("rst_load_slot", load_slot, 0);
        check_val("rst_busy", busy, 1);
        check_val("rst_timeout", load_timeout, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // power-up full reload
        wait_req(n);
        check_val("pwr_req_a_lat", n, 1);
        serve(0, 5, "pwr_a");
        wait_req(n);
        check_val("pwr_req_b_lat", n, 1);
        serve(1, 5, "pwr_b");
        wait_release(n);
        check_val("pwr_release_lat", n, H + 1);
        check_val("pwr_busy", busy, 0);

        // stray ack in IDLE
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        tick();
        check_val("idle_ack_busy", busy, 0);
        check_val("idle_ack_req", load_req, 0);

        // change at cycle 0 and cycle 10 -> req at cycle 28
        cart_changed = 1'b1;
        tick();
        c = 1;
        cart_changed = 1'b0;
        check_val("dbl_msx_reset_c1", msx_reset, 1);
        repeat (9) begin
            tick();
            c++;
        end
        cart_changed = 1'b1;
        tick();
        c++;
        cart_changed = 1'b0;
        while (!load_req && c < 200) begin
            tick();
            c++;
        end
        check_val("dbl_req_cycle", c, 2 * 0 + 10 + S + 2);
        serve(0, 2, "dbl_a");
        wait_req(n);
        serve(1, 2, "dbl_b");
        wait_release(n);
        check_val("dbl_release_lat", n, H + 1);

        // slot A empty: only a slot B request
        cart_typ[0] = CART_TYP_EMPTY;
        kick();
        wait_req(n);
        check_val("emp_req_lat", n, S + 2);
        serve(1, 3, "emp_b");
        wait_release(n);
        check_val("emp_release_lat", n, H + 1);
        cart_typ[0] = CART_TYP_ROM;

        // change during WAIT_B, then change coincident with ack in WAIT_A
        kick();
        wait_req(n);
        check_val("pend_req_a_lat", n, S + 1);
        serve(0, 2, "pend_a");
        wait_req(n);
        reset_request = 1'b1;
        tick();
        reset_request = 1'b0;
        serve(1, 2, "pend_b");
        wait_rerun(n, low_seen);
        check_val("pend_rerun_lat", n, H + S + 2);
        check_val("pend_reset_kept", low_seen, 0);
        check_val("pend_rerun_slot", load_slot, 0);
        load_ack      = 1'b1;
        reset_request = 1'b1;
        tick();
        load_ack      = 1'b0;
        reset_request = 1'b0;
        check_val("sim_ack_drop", load_req, 0);
        wait_req(n);
        check_val("sim_req_b_lat", n, 1);
        serve(1, 2, "sim_b");
        wait_rerun(n, low_seen);
        check_val("sim_rerun_lat", n, H + S + 2);
        serve(0, 2, "sim2_a");
        wait_req(n);
        serve(1, 2, "sim2_b");
        wait_release(n);
        check_val("sim2_release_lat", n, H + 1);

`ifdef CART_SEQ_TIMEOUT_EN
        kick();
        wait_req(n);
        n = 0;
        do begin
            tick();
            n++;
        end while (load_req && n < 200);
        check_val("to_req_high_cycles", n, T);
        check_val("to_flag_a", load_timeout, 2'b01);
        wait_req(n);
        check_val("to_req_b_lat", n, 1);
        serve(1, 2, "to_b");
        wait_release(n);
        check_val("to_release_lat", n, H + 1);
        check_val("to_flag_sticky", load_timeout, 2'b01);
`else
        kick();
        wait_req(n);
        repeat (40) tick();
        check_val("noto_req_held", load_req, 1);
        check_val("noto_flag", load_timeout, 0);
        serve(0, 2, "noto_a");
        wait_req(n);
        serve(1, 2, "noto_b");
        wait_release(n);
        check_val("noto_release_lat", n, H + 1);
`endif

        // async reset while WAIT_A
        kick();
        wait_req(n);
        check_val("ar_req_before", load_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_req_async", load_req, 0);
        check_val("ar_msx_reset_async", msx_reset, 1);
        check_val("ar_busy_async", busy, 1);
        check_val("ar_timeout_clr", load_timeout, 0);
        tick();
        reset = 1'b0;
        check_val("ar_req_after_rel", load_req, 0);
        wait_req(n);
        check_val("ar_restart_lat", n, 1);
        serve(0, 2, "ar_a");
        wait_req(n);
        serve(1, 2, "ar_b");
        wait_release(n);
        check_val("ar_release_lat", n, H + 1);
        check_val("ar_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
